// File: rtl/exec_pkg.sv
// Shared encodings for the execute-stage controller: op-hi codes, shift ext codes,
// PSR bit positions, FSM state encoding and the instruction decode function.
package exec_pkg;

    localparam logic [3:0] OPH_REG   = 4'h0;
    localparam logic [3:0] OPH_ADDI  = 4'h5;
    localparam logic [3:0] OPH_ADDUI = 4'h6;
    localparam logic [3:0] OPH_ADDCI = 4'h7;
    localparam logic [3:0] OPH_SHIFT = 4'h8;
    localparam logic [3:0] OPH_SUBI  = 4'h9;
    localparam logic [3:0] OPH_CMPI  = 4'hB;

    localparam logic [3:0] EXT_LSHI0 = 4'h0;
    localparam logic [3:0] EXT_LSHI1 = 4'h1;
    localparam logic [3:0] EXT_LSH   = 4'h4;

    localparam int PSR_Z = 4;
    localparam int PSR_C = 3;
    localparam int PSR_F = 2;
    localparam int PSR_N = 1;
    localparam int PSR_L = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEC  = 2'd1,
        ST_EXE  = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] b;
        logic        wr_en;
        logic        upd_en;
    } dec_t;

    // Anything not matched below stays all-zero, which is exactly the NOP encoding.
    function automatic dec_t decode(input logic [15:0] ins, input logic [15:0] rs_val);
        dec_t        d;
        logic [15:0] simm;
        logic [3:0]  ext;
        d    = '0;
        simm = {{8{ins[7]}}, ins[7:0]};
        ext  = ins[7:4];
        case (ins[15:12])
            OPH_REG: begin
                case (ext)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9,
                    4'hB, 4'hF: begin
                        d.opcode = {4'h0, ext};
                        d.b      = rs_val;
                        d.upd_en = 1'b1;
                        d.wr_en  = (ext != 4'hB) && (ext != 4'hF);
                    end
                    default: d = '0;
                endcase
            end
            OPH_ADDI, OPH_ADDCI: begin
                d.opcode = {ins[15:12], 4'h0};
                d.b      = simm;
                d.wr_en  = 1'b1;
                d.upd_en = 1'b1;
            end
            OPH_ADDUI: begin
                d.opcode = 8'h60;
                d.b      = {8'h00, ins[7:0]};
                d.wr_en  = 1'b1;
                d.upd_en = 1'b1;
            end
            OPH_SUBI: begin
                d.opcode = 8'h09;
                d.b      = simm;
                d.wr_en  = 1'b1;
                d.upd_en = 1'b1;
            end
            OPH_CMPI: begin
                d.opcode = 8'h0B;
                d.b      = simm;
                d.upd_en = 1'b1;
            end
            OPH_SHIFT: begin
                case (ext)
                    EXT_LSHI0, EXT_LSHI1: begin
                        d.opcode = 8'h80;
                        d.b      = {12'h000, ins[3:0]};
                        d.wr_en  = 1'b1;
                        d.upd_en = 1'b1;
                    end
                    EXT_LSH: begin
                        d.opcode = 8'h84;
                        d.b      = 16'h0000;
                        d.wr_en  = 1'b1;
                        d.upd_en = 1'b1;
                    end
                    default: d = '0;
                endcase
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/exec_ctrl_reg_file_16x16.sv
// 16x16 register file: two operand read ports, a debug read port, one synchronous write port.
// Build option EXEC_R0_HARDWIRED_EN makes R0 read as zero and discards writes to it.
module reg_file_16x16
    import exec_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [3:0]  raddr_a,
    output logic [15:0] rdata_a,
    input  logic [3:0]  raddr_b,
    output logic [15:0] rdata_b,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    logic [15:0] regs [NREGS];
    logic        wr_ok;

`ifdef EXEC_R0_HARDWIRED_EN
    assign wr_ok    = we && (waddr != 4'h0);
    assign rdata_a  = (raddr_a == 4'h0) ? 16'h0000 : regs[raddr_a];
    assign rdata_b  = (raddr_b == 4'h0) ? 16'h0000 : regs[raddr_b];
    assign dbg_data = (dbg_addr == 4'h0) ? 16'h0000 : regs[dbg_addr];
`else
    assign wr_ok    = we;
    assign rdata_a  = regs[raddr_a];
    assign rdata_b  = regs[raddr_b];
    assign dbg_data = regs[dbg_addr];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 16'h0000;
            end
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/exec_ctrl.sv
// Execute-stage controller feeding the 16-bit ALU; one instruction every four cycles.
// Build option EXEC_R0_HARDWIRED_EN is handled inside the register file.
//
// state   | meaning
// IDLE    | inst_ready high, waiting for a handshake
// DEC     | decode latched instruction, register ALU operands/opcode
// EXE     | ALU settles, capture result and flags
// WB      | write Rdest / update PSR as enabled, pulse done
module exec_ctrl
    import exec_pkg::*;
#(
    parameter int         NREGS     = 16,
    parameter logic [4:0] PSR_RESET = 5'b00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_valid,
    input  logic [15:0] inst,
    output logic        inst_ready,
    output logic        done,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [7:0]  alu_opcode,
    output logic        alu_cin,
    input  logic [15:0] alu_c,
    input  logic [4:0]  alu_flags,
    output logic [4:0]  psr,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    state_t      state_q, state_d;
    logic [15:0] inst_q;
    logic [15:0] res_q;
    logic [4:0]  flg_q;
    logic [4:0]  psr_q;
    logic        wr_q, upd_q;
    logic        rf_we;
    logic [15:0] rd_val, rs_val;
    dec_t        dec;

    reg_file_16x16 #(.NREGS(NREGS)) u_rf (
        .clk      (clk),
        .reset    (reset),
        .we       (rf_we),
        .waddr    (inst_q[11:8]),
        .wdata    (res_q),
        .raddr_a  (inst_q[11:8]),
        .rdata_a  (rd_val),
        .raddr_b  (inst_q[3:0]),
        .rdata_b  (rs_val),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    assign dec     = decode(inst_q, rs_val);
    assign psr     = psr_q;
    assign alu_cin = psr_q[PSR_C];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            inst_q     <= 16'h0000;
            alu_a      <= 16'h0000;
            alu_b      <= 16'h0000;
            alu_opcode <= 8'h00;
            wr_q       <= 1'b0;
            upd_q      <= 1'b0;
            res_q      <= 16'h0000;
            flg_q      <= 5'b00000;
            psr_q      <= PSR_RESET;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && inst_valid) begin
                inst_q <= inst;
            end
            if (state_q == ST_DEC) begin
                alu_a      <= rd_val;
                alu_b      <= dec.b;
                alu_opcode <= dec.opcode;
                wr_q       <= dec.wr_en;
                upd_q      <= dec.upd_en;
            end
            if (state_q == ST_EXE) begin
                res_q <= alu_c;
                flg_q <= alu_flags;
            end
            // PSR takes the ALU flags verbatim; NOPs never get here with upd_q set.
            if (state_q == ST_WB && upd_q) begin
                psr_q <= flg_q;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        inst_ready = 1'b0;
        done       = 1'b0;
        rf_we      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                inst_ready = 1'b1;
                if (inst_valid) begin
                    state_d = ST_DEC;
                end
            end
            ST_DEC: state_d = ST_EXE;
            ST_EXE: state_d = ST_WB;
            ST_WB: begin
                done    = 1'b1;
                rf_we   = wr_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
